// File: rtl/axi_addr_router.sv
// AXI AW/AR address decoder for one master and one direction. It routes the request to a region slave or to
// the default slave, and stays locked to one slave while any transactions are still outstanding.
module axi_addr_router #(
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 7,
  parameter int MAX_OUTST  = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE = {
    32'h5000_0000, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000,
    32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] LIMIT = {
    32'h8FFF_FFFF, 32'h4001_0000, 32'h2080_0000, 32'h1000_0400,
    32'h0003_0000, 32'h0002_0000, 32'h0000_4000},
  localparam int SEL_W = $clog2(NUM_SLAVES + 1),
  localparam int CNT_W = $clog2(MAX_OUTST + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic                  validm_i,
  output logic                  readym_o,
  output logic [NUM_SLAVES:0]   valid_s_o,
  input  logic [NUM_SLAVES:0]   ready_s_i,
  input  logic                  done_i,
  output logic [SEL_W-1:0]      sel_o,
  output logic [CNT_W-1:0]      outst_o,
  output logic [7:0]            decerr_cnt_o,
  output logic                  underflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCKED,
    ST_FULL
  } state_t;

  localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] outst_q;
  logic [CNT_W-1:0] outst_d;
  logic [7:0]       decerr_q;
  logic             underflow_q;
  logic [SEL_W-1:0] tgt;
  state_t           state;
  logic             stall;
  logic             accept;
  logic             dec_ok;

  // The lowest-index region that hits wins; a miss goes to the default slave.
  always_comb begin
    tgt = DEF_SEL;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (addr_i >= BASE[i*ADDR_W +: ADDR_W] && addr_i < LIMIT[i*ADDR_W +: ADDR_W]) begin
        tgt = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state = ST_LOCKED;
    if (outst_q == '0) begin
      state = ST_IDLE;
    end else if (outst_q == CNT_FULL) begin
      state = ST_FULL;
    end
  end

  // The stall decision uses registered state only. A done_i never frees a slot in the same cycle.
  always_comb begin
    stall     = (state == ST_FULL) || (state == ST_LOCKED && tgt != sel_q);
    valid_s_o = '0;
    readym_o  = 1'b0;
    if (!stall) begin
      valid_s_o[tgt] = validm_i;
      readym_o       = validm_i & ready_s_i[tgt];
    end
  end

  assign accept = validm_i & readym_o;
  assign dec_ok = done_i && (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    if (accept && !dec_ok) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (!accept && dec_ok) begin
      outst_d = outst_q - CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sel_q       <= '0;
      outst_q     <= '0;
      decerr_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (accept) begin
        sel_q <= tgt;
        if (tgt == DEF_SEL) begin
          decerr_q <= sat_inc(decerr_q);
        end
      end
      if (done_i && outst_q == '0) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign sel_o        = sel_q;
  assign outst_o      = outst_q;
  assign decerr_cnt_o = decerr_q;
  assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_axi_addr_router.sv
// Scoreboard bench for axi_addr_router. A region/count reference model predicts each cycle's outputs, and a
// monitor on the falling edge compares them with the DUT.
module tb_axi_addr_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        validm = 1'b0;
  logic        readym;
  logic [7:0]  valid_s;
  logic [7:0]  ready_s = '0;
  logic        done = 1'b0;
  logic [2:0]  sel;
  logic [2:0]  outst;
  logic [7:0]  decerr;
  logic        underflow;

  int compared = 0;
  int mismatched = 0;

  axi_addr_router dut (
    .ACLK(clk), .ARESETn(rst_n), .addr_i(addr), .validm_i(validm), .readym_o(readym),
    .valid_s_o(valid_s), .ready_s_i(ready_s), .done_i(done), .sel_o(sel), .outst_o(outst),
    .decerr_cnt_o(decerr), .underflow_o(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vs;
    logic       rd;
    logic [2:0] sel;
    logic [2:0] outst;
    logic [7:0] dec;
    logic       unf;
  } exp_t;

  exp_t sb[$];

  logic [31:0] base_m  [7] = '{32'h0, 32'h1_0000, 32'h2_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000, 32'h5000_0000};
  logic [31:0] limit_m [7] = '{32'h4000, 32'h2_0000, 32'h3_0000, 32'h1000_0400, 32'h2080_0000, 32'h4001_0000, 32'h8FFF_FFFF};

  int m_sel = 0, m_outst = 0, m_dec = 0;
  bit m_unf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    for (int i = 0; i < 7; i++) begin
      if (a >= base_m[i] && a < limit_m[i]) return i;
    end
    return 7;
  endfunction

  // The model sees the state before the edge, predicts this cycle's outputs, then applies the edge.
  task automatic step(input logic [31:0] a, input logic v, input logic [7:0] rdy, input logic d);
    exp_t e;
    int   t;
    bit   stl, acc;
    @(posedge clk);
    #1;
    addr = a; validm = v; ready_s = rdy; done = d;
    t   = region_of(a);
    stl = (m_outst != 0 && t != m_sel) || m_outst == 4;
    acc = !stl && v && rdy[t];
    e.vs    = (!stl && v) ? (8'd1 << t) : 8'd0;
    e.rd    = acc;
    e.sel   = 3'(m_sel);
    e.outst = 3'(m_outst);
    e.dec   = 8'(m_dec);
    e.unf   = m_unf;
    sb.push_back(e);
    if (acc) begin
      m_sel = t;
      if (t == 7 && m_dec < 255) m_dec++;
    end
    if (d && m_outst == 0) m_unf = 1;
    if (acc && d) begin
      if (m_outst == 0) m_outst = 1;
    end else if (acc) begin
      m_outst++;
    end else if (d && m_outst > 0) begin
      m_outst--;
    end
  endtask

  task automatic idle(input logic d);
    step(32'h0, 1'b0, 8'hFF, d);
  endtask

  task automatic now_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    @(negedge clk);
    #1;
    check(name, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("valid_s", {24'd0, valid_s}, {24'd0, e.vs});
        check("readym", {31'd0, readym}, {31'd0, e.rd});
        check("sel", {29'd0, sel}, {29'd0, e.sel});
        check("outst", {29'd0, outst}, {29'd0, e.outst});
        check("decerr", {24'd0, decerr}, {24'd0, e.dec});
        check("underflow", {31'd0, underflow}, {31'd0, e.unf});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [31:0] pick [16] = '{32'h3FFC, 32'h4000, 32'h1_0000, 32'h2_0000, 32'h2_FFFC, 32'h3_0000,
                             32'h1000_03FC, 32'h1000_0400, 32'h2000_0000, 32'h207F_FFFC, 32'h4000_FFFC,
                             32'h4001_0000, 32'h5000_0000, 32'h8FFF_FFFC, 32'h9000_0000, 32'h0};
  logic [31:0] sweep [6] = '{32'h3FFC, 32'h4000, 32'h1_0000, 32'h1000_03FC, 32'h2080_0000, 32'h5000_0000};

  initial begin : stim
    logic [31:0] ra;
    // Reset and idle
    repeat (3) @(posedge clk);
    #2;
    check("rst_outst", {29'd0, outst}, 32'd0);
    check("rst_valid", {24'd0, valid_s}, 32'd0);
    rst_n = 1'b1;
    idle(1'b0);
    idle(1'b0);

    // Decode sweep, releasing the lock after each accept
    foreach (sweep[i]) begin
      step(sweep[i], 1'b1, 8'hFF, 1'b0);
      idle(1'b1);
    end
    idle(1'b0);
    now_check("sweep_decerr", {24'd0, decerr}, 32'd2);

    // Ordering lock
    step(32'h2_0000, 1'b1, 8'hFF, 1'b0);
    step(32'h2000_0000, 1'b1, 8'hFF, 1'b0);
    step(32'h2000_0000, 1'b1, 8'hFF, 1'b1);
    step(32'h2000_0000, 1'b1, 8'hFF, 1'b0);
    idle(1'b1);

    // Full, and a done_i that does not bypass the full stall
    for (int i = 0; i < 4; i++) step(32'h100 * i, 1'b1, 8'hFF, 1'b0);
    step(32'h400, 1'b1, 8'hFF, 1'b1);
    step(32'h400, 1'b1, 8'hFF, 1'b0);
    idle(1'b0);
    now_check("full_outst", {29'd0, outst}, 32'd4);
    repeat (4) idle(1'b1);

    // Simultaneous accept and done
    step(32'h1_0000, 1'b1, 8'hFF, 1'b0);
    step(32'h1_0004, 1'b1, 8'hFF, 1'b0);
    step(32'h1_0008, 1'b1, 8'hFF, 1'b1);
    idle(1'b0);
    now_check("simul_outst", {29'd0, outst}, 32'd2);
    repeat (2) idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    now_check("underflow_set", {31'd0, underflow}, 32'd1);

    // Saturation of the decode-error counter
    for (int i = 0; i < 300; i++) step(32'h9000_0000, 1'b1, 8'hFF, 1'b1);
    idle(1'b0);
    now_check("decerr_sat", {24'd0, decerr}, 32'd255);
    idle(1'b1);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) step(32'h6000_0000, 1'b1, 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    validm = 1'b0; done = 1'b0;
    rst_n = 1'b0;
    #2;
    check("arst_outst", {29'd0, outst}, 32'd0);
    check("arst_decerr", {24'd0, decerr}, 32'd0);
    check("arst_underflow", {31'd0, underflow}, 32'd0);
    check("arst_sel", {29'd0, sel}, 32'd0);
    m_sel = 0; m_outst = 0; m_dec = 0; m_unf = 0;
    #5;
    rst_n = 1'b1;
    idle(1'b0);

    // Random traffic with random slave readiness and completions
    for (int i = 0; i < 600; i++) begin
      ra = pick[$urandom_range(15)];
      if ($urandom_range(7) == 0) ra = $urandom;
      step(ra, 1'($urandom_range(3) != 0), 8'($urandom), 1'($urandom_range(2) == 0));
    end
    idle(1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
